fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADD_WIDTH, default 5, instruction address width; SHALL match the PC stage.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, addi x0,x0,0, the value loaded into IFID_Instr on reset and flush.
REQ-003 Clk  in  1  clock; all state updates on the rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-low.
REQ-005 PC_in  in  ADD_WIDTH  current PC from the PC stage.
REQ-006 PC_Stall  out  1  drives the PC stage Stall input; 1 holds PC.
REQ-007 Flush  in  1  jump taken; same signal as the PC stage J input.
REQ-008 IMem_Req  out  1  instruction memory request.
REQ-009 IMem_Addr  out  ADD_WIDTH  request address.
REQ-010 IMem_Gnt  in  1  request accepted this cycle.
REQ-011 IMem_RValid  in  1  read data valid; at most one per granted request, at least 1 cycle after the grant.
REQ-012 IMem_RData  in  32  instruction word.
REQ-013 ID_Stall  in  1  decode stage cannot accept; IF/ID register holds.
REQ-014 IFID_Valid  out  1; IFID_Instr  out  32; IFID_PC  out  ADD_WIDTH -- registered IF/ID pipeline outputs.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT and HOLD; at most one request outstanding.
REQ-016 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-017 IMem_Req SHALL be 1 only in REQ; IMem_Addr SHALL equal PC_in combinationally; the address may change while ungranted only after a Flush.
REQ-018 REQ with IMem_Gnt=1 SHALL latch PC_in into req_pc and go to WAIT; without a grant it stays in REQ.
REQ-019 PC_Stall SHALL be 0 when (state==REQ and IMem_Gnt) or Flush, else 1, so PC advances by 4 exactly once per grant and loads the jump target on Flush.
REQ-020 WAIT with RValid, no Flush, no drop flag and ID_Stall=0: IFID_Instr<=RData, IFID_PC<=req_pc, IFID_Valid<=1, then go to REQ.
REQ-021 WAIT with RValid, no Flush, no drop flag and ID_Stall=1: capture RData/req_pc into the hold buffer and go to HOLD; IF/ID is unchanged.
REQ-022 HOLD SHALL load the buffer into IF/ID (Valid<=1) in the first cycle with ID_Stall=0, then go to REQ.
REQ-023 While ID_Stall=1, IFID_Valid/Instr/PC SHALL hold, unless a Flush occurs.
REQ-024 When ID_Stall=0 and no instruction is delivered that cycle, IFID_Valid<=0 (bubble); Instr/PC hold.
REQ-025 Flush SHALL override ID_Stall: next cycle IFID_Valid=0 and IFID_Instr=NOP_INSTR.
REQ-026 Flush in REQ with Gnt: the request is granted but SHALL set the drop flag and go to WAIT.
REQ-027 Flush in REQ without Gnt: stay in REQ; no drop flag.
REQ-028 Flush in WAIT without RValid: set the drop flag and stay in WAIT.
REQ-029 Flush in WAIT with RValid, or RValid while the drop flag is set: discard the data, clear the drop flag and go to REQ.
REQ-030 Flush in HOLD SHALL discard the buffer and go to REQ.
REQ-031 Latency: Gnt in cycle n and RValid in n+1 gives IFID_Valid=1 in n+2; peak throughput is 1 instruction per 2 cycles.

Reset
REQ-032 While Rst=0, outputs SHALL be: state IDLE, IMem_Req=0, PC_Stall=1 (when Flush=0), IFID_Valid=0, IFID_Instr=NOP_INSTR, IFID_PC=0, drop flag 0, hold buffer 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; a later RValid for it while the FSM is in IDLE or REQ SHALL be ignored.

Verification
REQ-034 Reset release, memory Gnt same-cycle, RValid next cycle, RData=0x00500093, ID_Stall=0 -> IMem_Addr=0; IFID_Valid=1 with PC=0 two cycles after the grant; next request at address 4.
REQ-035 Delay Gnt by 3 cycles -> IMem_Req stays 1 and PC_Stall stays 1 throughout; PC_in is not incremented until the grant cycle.
REQ-036 ID_Stall=1 when RValid arrives, held 4 cycles -> FSM in HOLD, IF/ID unchanged; instruction appears in IF/ID the cycle after ID_Stall drops.
REQ-037 Flush with target 0x10 while in WAIT for address 8 -> the address-8 data is discarded, IFID_Valid=0/NOP, and the next request is to address 0x10.
REQ-038 Flush coincident with Gnt at address 4 -> response dropped, PC loads the target, no IFID_Valid for address 4.
REQ-039 Rst pulsed low while in WAIT, then a stray RValid arrives -> outputs return to reset values; the stray data never reaches IF/ID.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time and delivers words into
// the IF/ID pipeline register. It honours decode back-pressure and discards responses after a jump.
module fetch_unit #(
  parameter int          ADD_WIDTH = 5,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [ADD_WIDTH-1:0] PC_in,
  output logic                 PC_Stall,
  input  logic                 Flush,
  output logic                 IMem_Req,
  output logic [ADD_WIDTH-1:0] IMem_Addr,
  input  logic                 IMem_Gnt,
  input  logic                 IMem_RValid,
  input  logic [31:0]          IMem_RData,
  input  logic                 ID_Stall,
  output logic                 IFID_Valid,
  output logic [31:0]          IFID_Instr,
  output logic [ADD_WIDTH-1:0] IFID_PC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic                   drop_r, drop_s;
  logic [ADD_WIDTH-1:0]   req_pc_r, req_pc_s;
  logic [ADD_WIDTH-1:0]   hold_pc_r, hold_pc_s;
  logic [31:0]            hold_instr_r, hold_instr_s;
  logic                   deliver_s;
  logic [31:0]            dlv_instr_s;
  logic [ADD_WIDTH-1:0]   dlv_pc_s;
  logic                   ifid_valid_s;
  logic [31:0]            ifid_instr_s;
  logic [ADD_WIDTH-1:0]   ifid_pc_s;

  assign IMem_Req  = (state_r == REQ);
  assign IMem_Addr = PC_in;
  assign PC_Stall  = ~(((state_r == REQ) && IMem_Gnt) || Flush);

  // Next-state, drop flag, hold buffer and delivery selection.
  always_comb begin
    state_s      = state_r;
    drop_s       = drop_r;
    req_pc_s     = req_pc_r;
    hold_pc_s    = hold_pc_r;
    hold_instr_s = hold_instr_r;
    deliver_s    = 1'b0;
    dlv_instr_s  = hold_instr_r;
    dlv_pc_s     = hold_pc_r;
    case (state_r)
      IDLE: state_s = REQ;
      REQ: begin
        if (IMem_Gnt) begin
          // A grant coinciding with a jump is still outstanding; its data gets dropped.
          req_pc_s = PC_in;
          drop_s   = Flush;
          state_s  = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (IMem_RValid) begin
          if (Flush || drop_r) begin
            drop_s  = 1'b0;
            state_s = REQ;
          end else if (!ID_Stall) begin
            deliver_s   = 1'b1;
            dlv_instr_s = IMem_RData;
            dlv_pc_s    = req_pc_r;
            state_s     = REQ;
          end else begin
            hold_instr_s = IMem_RData;
            hold_pc_s    = req_pc_r;
            state_s      = HOLD;
          end
        end else if (Flush) begin
          drop_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (Flush) begin
          state_s = REQ;
        end else if (!ID_Stall) begin
          deliver_s = 1'b1;
          state_s   = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // IF/ID next value: jump kills, delivery loads, free decode without delivery bubbles.
  always_comb begin
    ifid_valid_s = IFID_Valid;
    ifid_instr_s = IFID_Instr;
    ifid_pc_s    = IFID_PC;
    if (Flush) begin
      ifid_valid_s = 1'b0;
      ifid_instr_s = NOP_INSTR;
    end else if (deliver_s) begin
      ifid_valid_s = 1'b1;
      ifid_instr_s = dlv_instr_s;
      ifid_pc_s    = dlv_pc_s;
    end else if (!ID_Stall) begin
      ifid_valid_s = 1'b0;
    end else begin
      ifid_valid_s = IFID_Valid;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r      <= IDLE;
      drop_r       <= 1'b0;
      req_pc_r     <= {ADD_WIDTH{1'b0}};
      hold_pc_r    <= {ADD_WIDTH{1'b0}};
      hold_instr_r <= 32'h0000_0000;
      IFID_Valid   <= 1'b0;
      IFID_Instr   <= NOP_INSTR;
      IFID_PC      <= {ADD_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      drop_r       <= drop_s;
      req_pc_r     <= req_pc_s;
      hold_pc_r    <= hold_pc_s;
      hold_instr_r <= hold_instr_s;
      IFID_Valid   <= ifid_valid_s;
      IFID_Instr   <= ifid_instr_s;
      IFID_PC      <= ifid_pc_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a PC stage, a single-outstanding memory and an instruction-flow model.
// Directed scenarios are followed by randomized traffic.
module tb_fetch_unit;
  localparam int          AW  = 5;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [AW-1:0] PC_in = '0;
  logic          PC_Stall;
  logic          Flush = 1'b0;
  logic          IMem_Req;
  logic [AW-1:0] IMem_Addr;
  logic          IMem_Gnt = 1'b0;
  logic          IMem_RValid = 1'b0;
  logic [31:0]   IMem_RData = '0;
  logic          ID_Stall = 1'b0;
  logic          IFID_Valid;
  logic [31:0]   IFID_Instr;
  logic [AW-1:0] IFID_PC;

  int checks = 0;
  int errors = 0;

  // Instruction-flow model: a fetch in flight (maybe killed by a jump), a word parked
  // behind a stalled decode, the visible IF/ID contents and the program counter.
  bit            m_idle, m_infl, m_kill, m_buf, m_valid;
  logic [AW-1:0] m_infl_pc, m_buf_pc, m_pc, pc_m;
  logic [31:0]   m_buf_instr, m_instr;

  // Memory: one outstanding response with a countdown.
  bit            mem_busy = 1'b0;
  int            mem_cnt = 0;

  fetch_unit #(.ADD_WIDTH(AW), .NOP_INSTR(NOP)) dut (
    .Clk(Clk), .Rst(Rst), .PC_in(PC_in), .PC_Stall(PC_Stall), .Flush(Flush),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Gnt(IMem_Gnt),
    .IMem_RValid(IMem_RValid), .IMem_RData(IMem_RData), .ID_Stall(ID_Stall),
    .IFID_Valid(IFID_Valid), .IFID_Instr(IFID_Instr), .IFID_PC(IFID_PC)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; Flush = 1'b0; ID_Stall = 1'b0; IMem_Gnt = 1'b0;
    IMem_RValid = 1'b0; IMem_RData = '0; PC_in = '0;
    #1;
    chk("rst_req", 32'(IMem_Req), 32'd0);
    chk("rst_pc_stall", 32'(PC_Stall), 32'd1);
    chk("rst_valid", 32'(IFID_Valid), 32'd0);
    chk("rst_instr", IFID_Instr, NOP);
    chk("rst_pc", 32'(IFID_PC), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    m_idle = 1'b1; m_infl = 1'b0; m_kill = 1'b0; m_buf = 1'b0;
    m_valid = 1'b0; m_instr = NOP; m_pc = '0; pc_m = '0;
    m_infl_pc = '0; m_buf_pc = '0; m_buf_instr = '0;
  endtask

  // One clock: drive inputs at the falling edge, compare against the model, advance it.
  task automatic step(input bit f, input bit st, input bit g, input bit rv,
                      input logic [31:0] rd, input logic [AW-1:0] tgt);
    bit            exp_req, exp_ps, dlv;
    logic [31:0]   d_instr;
    logic [AW-1:0] d_pc;
    @(negedge Clk);
    Flush = f; ID_Stall = st; IMem_Gnt = g; IMem_RValid = rv; IMem_RData = rd; PC_in = pc_m;
    #1;
    exp_req = !m_idle && !m_infl && !m_buf;
    exp_ps  = !((exp_req && g) || f);
    chk("imem_req", 32'(IMem_Req), 32'(exp_req));
    chk("pc_stall", 32'(PC_Stall), 32'(exp_ps));
    chk("imem_addr", 32'(IMem_Addr), 32'(pc_m));
    chk("ifid_valid", 32'(IFID_Valid), 32'(m_valid));
    chk("ifid_instr", IFID_Instr, m_instr);
    chk("ifid_pc", 32'(IFID_PC), 32'(m_pc));
    dlv = 1'b0; d_instr = '0; d_pc = '0;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (exp_req) begin
      if (g) begin m_infl = 1'b1; m_infl_pc = pc_m; m_kill = f; end
    end else if (m_infl) begin
      if (rv) begin
        m_infl = 1'b0;
        if (!(m_kill || f)) begin
          if (!st) begin dlv = 1'b1; d_instr = rd; d_pc = m_infl_pc; end
          else begin m_buf = 1'b1; m_buf_instr = rd; m_buf_pc = m_infl_pc; end
        end
        m_kill = 1'b0;
      end else if (f) begin
        m_kill = 1'b1;
      end
    end else if (m_buf) begin
      if (f) m_buf = 1'b0;
      else if (!st) begin dlv = 1'b1; d_instr = m_buf_instr; d_pc = m_buf_pc; m_buf = 1'b0; end
    end
    if (f) begin m_valid = 1'b0; m_instr = NOP; end
    else if (dlv) begin m_valid = 1'b1; m_instr = d_instr; m_pc = d_pc; end
    else if (!st) m_valid = 1'b0;
    if (f) pc_m = tgt;
    else if (!exp_ps) pc_m = pc_m + AW'(4);
    @(posedge Clk);
  endtask

  initial begin
    do_reset();
    // Basic fetch: grant at once, data next cycle.
    step(0, 0, 0, 0, 32'h0, 5'h0);
    step(0, 0, 1, 0, 32'h0, 5'h0);
    #2 chk("a_req_after_gnt", 32'(IMem_Req), 32'd0);
    step(0, 0, 0, 1, 32'h00500093, 5'h0);
    #2 chk("a_valid", 32'(IFID_Valid), 32'd1);
    chk("a_instr", IFID_Instr, 32'h00500093);
    chk("a_pc", 32'(IFID_PC), 32'd0);
    chk("a_next_req", 32'(IMem_Req), 32'd1);
    chk("a_next_addr", 32'(IMem_Addr), 32'd4);
    // Grant delayed three cycles.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'h0, 5'h0);
      #2 chk("b_req_held", 32'(IMem_Req), 32'd1);
      chk("b_pc_stall", 32'(PC_Stall), 32'd1);
      chk("b_addr", 32'(IMem_Addr), 32'd4);
      chk("b_bubble", 32'(IFID_Valid), 32'd0);
    end
    step(0, 0, 1, 0, 32'h0, 5'h0);
    // Decode stalled when data arrives, for four cycles.
    step(0, 1, 0, 1, 32'hAAAA0001, 5'h0);
    for (int i = 0; i < 3; i++) begin
      #2 chk("c_hold_valid", 32'(IFID_Valid), 32'd0);
      chk("c_hold_instr", IFID_Instr, 32'h00500093);
      chk("c_no_req", 32'(IMem_Req), 32'd0);
      step(0, 1, 0, 0, 32'h0, 5'h0);
    end
    step(0, 0, 0, 0, 32'h0, 5'h0);
    #2 chk("c_valid", 32'(IFID_Valid), 32'd1);
    chk("c_instr", IFID_Instr, 32'hAAAA0001);
    chk("c_pc", 32'(IFID_PC), 32'd4);
    // Jump to 0x10 while waiting for address 8.
    step(0, 0, 1, 0, 32'h0, 5'h0);
    step(1, 0, 0, 0, 32'h0, 5'h10);
    #2 chk("d_valid", 32'(IFID_Valid), 32'd0);
    chk("d_nop", IFID_Instr, NOP);
    step(0, 0, 0, 1, 32'hBBBB0002, 5'h0);
    #2 chk("d_drop_valid", 32'(IFID_Valid), 32'd0);
    chk("d_req", 32'(IMem_Req), 32'd1);
    chk("d_addr", 32'(IMem_Addr), 32'h10);
    // Jump without grant to 4, then jump coinciding with the grant at 4.
    step(1, 0, 0, 0, 32'h0, 5'h04);
    #2 chk("e_still_req", 32'(IMem_Req), 32'd1);
    step(1, 0, 1, 0, 32'h0, 5'h1C);
    step(0, 0, 0, 1, 32'hCCCC0003, 5'h0);
    #2 chk("e_dropped", 32'(IFID_Valid), 32'd0);
    chk("e_req", 32'(IMem_Req), 32'd1);
    step(0, 0, 1, 0, 32'h0, 5'h0);
    step(0, 0, 0, 1, 32'hDDDD0004, 5'h0);
    #2 chk("e_valid", 32'(IFID_Valid), 32'd1);
    chk("e_pc", 32'(IFID_PC), 32'h1C);
    chk("e_instr", IFID_Instr, 32'hDDDD0004);
    // Reset while waiting, then a stray response.
    step(0, 0, 1, 0, 32'h0, 5'h0);
    do_reset();
    step(0, 0, 0, 0, 32'h0, 5'h0);
    step(0, 0, 0, 1, 32'hEEEE0005, 5'h0);
    #2 chk("f_stray_valid", 32'(IFID_Valid), 32'd0);
    chk("f_stray_instr", IFID_Instr, NOP);
    chk("f_req", 32'(IMem_Req), 32'd1);
    // Randomized traffic.
    mem_busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit            f, st, g, rv;
      logic [31:0]   rd;
      logic [AW-1:0] tgt;
      #1;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        mem_busy = 1'b0;
      end else begin
        rv = 1'b0;
        if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin rv = 1'b1; mem_busy = 1'b0; end
        end
        g = IMem_Req && ($urandom_range(0, 2) != 0);
        if (g) begin mem_busy = 1'b1; mem_cnt = $urandom_range(1, 3); end
        rd  = $urandom;
        f   = ($urandom_range(0, 7) == 0);
        st  = ($urandom_range(0, 2) == 0);
        tgt = AW'($urandom_range(0, 7) * 4);
        step(f, st, g, rv, rd, tgt);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
